// File: rtl/udma_adc_ts_pkg.sv
// ---------------------------------------------------------------------------
// udma_adc_ts_pkg
// Shared types for the uDMA ADC timestamp generator.
//   ts_entry_t      : queued stamp {chid, data}. Fields are sized for the
//                     widest supported configuration. Users slice them down
//                     to TS_CHID_WIDTH / TS_DATA_WIDTH.
//   ts_out_state_e  : output publisher states.
//   HOLD_CYCLES_DEF : default spacing between ts_valid_o toggles.
// ---------------------------------------------------------------------------
package udma_adc_ts_pkg;

    localparam int unsigned TS_CHID_MAX_W   = 8;
    localparam int unsigned TS_DATA_MAX_W   = 32;
    localparam int unsigned HOLD_CYCLES_DEF = 16;

    typedef struct packed {
        logic [TS_CHID_MAX_W-1:0] chid;
        logic [TS_DATA_MAX_W-1:0] data;
    } ts_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ts_out_state_e;

endpackage

// File: rtl/udma_adc_ts_fifo.sv
// ---------------------------------------------------------------------------
// udma_adc_ts_fifo
// Single-clock stamp queue with FIFO_DEPTH entries of ts_entry_t.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   push_i, entry_i  : write request and data (ignored while full)
//   pop_i            : read request (ignored while empty)
//   entry_o          : head entry (valid while !empty_o)
//   full_o, empty_o  : status
// The pointers carry one extra MSB. Equal pointers mean empty. Equal
// indices with differing MSBs mean full.
// ---------------------------------------------------------------------------
module udma_adc_ts_fifo
    import udma_adc_ts_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  ts_entry_t entry_i,
    input  logic      pop_i,
    output ts_entry_t entry_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    ts_entry_t   r_mem [FIFO_DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty_o   = (r_wptr == r_rptr);
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign entry_o   = r_mem[r_rptr[AW-1:0]];

    // Storage array and write pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= entry_i;
            r_wptr                <= r_wptr + PTR_ONE;
        end
    end

    // Read pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr <= '0;
        end else if (w_do_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/udma_adc_ts_gen.sv
// ---------------------------------------------------------------------------
// udma_adc_ts_gen
// Timestamp event generator in the ts clock domain. It captures a
// free-running counter on rising edges of the event inputs and queues the
// stamps. Each stamp is published as a chid/data pair announced by a toggle
// on ts_valid_o. The pair is held for at least HOLD_CYCLES so a downstream
// toggle synchroniser can capture it.
// Ports:
//   ts_clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i             : counter run / event capture enable
//   clr_i            : synchronous counter clear (priority over en_i)
//   evt_i[NUM_CH]    : event inputs, rising edge = event
//   ovf_clr_i        : clears overflow_o (a same-cycle set wins)
//   ts_valid_o       : toggles once per published stamp
//   ts_chid_o        : channel ID of the current stamp
//   ts_data_o        : timestamp of the current stamp
//   overflow_o       : sticky lost-event flag
// Constraints: TS_DATA_WIDTH <= 32, TS_CHID_WIDTH <= 8, HOLD_CYCLES >= 4.
// ---------------------------------------------------------------------------
module udma_adc_ts_gen
    import udma_adc_ts_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned TS_DATA_WIDTH = 28,
    parameter int unsigned TS_CHID_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
    input  logic                     ts_clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [NUM_CH-1:0]        evt_i,
    input  logic                     ovf_clr_i,
    output logic                     ts_valid_o,
    output logic [TS_CHID_WIDTH-1:0] ts_chid_o,
    output logic [TS_DATA_WIDTH-1:0] ts_data_o,
    output logic                     overflow_o
);

    localparam int unsigned            HW        = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0]          HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]          HOLD_ONE  = HW'(1);
    localparam logic [TS_DATA_WIDTH-1:0] CNT_ONE = TS_DATA_WIDTH'(1);

    logic [TS_DATA_WIDTH-1:0] r_cnt;
    logic [NUM_CH-1:0]        r_evt_prev;
    logic [NUM_CH-1:0]        w_edge;
    logic [NUM_CH-1:0]        r_pend_vld;
    logic [TS_DATA_WIDTH-1:0] r_pend_ts [NUM_CH];
    logic [NUM_CH-1:0]        w_grant;
    logic                     w_found;
    logic                     w_drop;
    ts_entry_t                w_push_entry;
    ts_entry_t                w_head;
    logic                     w_head_unused;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    ts_out_state_e            r_state;
    ts_out_state_e            w_state_nxt;
    logic [HW-1:0]            r_hold;
    logic [HW-1:0]            w_hold_nxt;
    logic                     r_valid;
    logic [TS_CHID_WIDTH-1:0] r_chid;
    logic [TS_DATA_WIDTH-1:0] r_data;
    logic                     r_ovf;

    // Only the low slices of the wide queue entry are published.
    assign w_head_unused = ^w_head;

    // Free-running timestamp counter. The clear wins over the run enable.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Previous event levels. These track even while disabled, so a level that
    // was already high when en_i rises does not count as an edge.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt_prev <= '0;
        end else begin
            r_evt_prev <= evt_i;
        end
    end

    assign w_edge = evt_i & ~r_evt_prev & {NUM_CH{en_i}};

    // Fixed-priority arbiter: lowest pending channel moves to the FIFO.
    always_comb begin
        w_grant      = '0;
        w_found      = 1'b0;
        w_push_entry = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_pend_vld[c] && !w_found && !w_fifo_full) begin
                w_grant[c]        = 1'b1;
                w_found           = 1'b1;
                w_push_entry.chid = TS_CHID_MAX_W'(c);
                w_push_entry.data = TS_DATA_MAX_W'(r_pend_ts[c]);
            end else begin
                w_grant[c] = 1'b0;
            end
        end
    end

    assign w_push = |w_grant;
    // An edge is lost only if its channel is still pending and is not leaving this cycle.
    assign w_drop = |(w_edge & r_pend_vld & ~w_grant);

    // Per-channel pending registers. A new edge on a channel being dequeued reloads it.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_vld <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pend_ts[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_edge[c] && (!r_pend_vld[c] || w_grant[c])) begin
                    r_pend_vld[c] <= 1'b1;
                    r_pend_ts[c]  <= r_cnt;
                end else if (w_grant[c]) begin
                    r_pend_vld[c] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flag. A same-cycle set beats the clear.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    udma_adc_ts_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ts_clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .entry_i (w_push_entry),
        .pop_i   (w_pop),
        .entry_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Publisher next state. HOLD leaves when the decremented count reaches 0,
    // so consecutive toggles are exactly HOLD_CYCLES apart.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = HOLD_LOAD;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_hold_nxt = r_hold - HOLD_ONE;
                if (r_hold <= HOLD_ONE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Publisher state, hold counter and registered output pair.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_chid  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_pop) begin
                r_valid <= ~r_valid;
                r_chid  <= w_head.chid[TS_CHID_WIDTH-1:0];
                r_data  <= w_head.data[TS_DATA_WIDTH-1:0];
            end
        end
    end

    assign ts_valid_o = r_valid;
    assign ts_chid_o  = r_chid;
    assign ts_data_o  = r_data;
    assign overflow_o = r_ovf;

endmodule
